if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 41 ++++
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode handshake, branch redirect, fetch-to-decode payload
// and the instruction SRAM port. The master side is the fetch stage.
interface if_stage_if;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned BR_BUS_W = 33;
  localparam int unsigned FS_BUS_W = 64;

  logic                ds_allowin;
  logic [BR_BUS_W-1:0] br_bus;
  logic                fs_to_ds_valid;
  logic [FS_BUS_W-1:0] fs_to_ds_bus;
  logic                inst_sram_en;
  logic [3:0]          inst_sram_we;
  logic [PC_W-1:0]     inst_sram_addr;
  logic [PC_W-1:0]     inst_sram_wdata;
  logic [PC_W-1:0]     inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with a combinational pre-IF next-pc selector.
// Optional macro FS_INST_BUF_EN builds a holding register that keeps the IF
// instruction stable across decode stalls even if the SRAM output changes.
module if_stage (
  input  logic         clk,
  input  logic         reset,
  if_stage_if.master   bus
);
  localparam int unsigned PC_W       = 32;
  localparam logic [31:0] RESET_PC   = 32'h1BFF_FFFC;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic        FS_READY_GO = 1'b1;

  logic            fs_valid;
  logic [PC_W-1:0] fs_pc;
  logic [PC_W-1:0] fs_inst;

  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            to_fs_valid;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] nextpc;
  logic            fs_allowin;

  // Pre-IF: pick the next fetch address; a taken branch overrides sequential flow.
  always_comb begin
    br_taken    = bus.br_bus[32];
    br_target   = bus.br_bus[31:0];
    to_fs_valid = ~reset;
    seq_pc      = fs_pc + PC_STEP;
    nextpc      = br_taken ? br_target : seq_pc;
    fs_allowin  = !fs_valid || (FS_READY_GO && bus.ds_allowin);
  end

  // IF register: advance only when IF can accept; the held branch redirects on that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC;
    end else if (to_fs_valid && fs_allowin) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

`ifdef FS_INST_BUF_EN
  logic            buf_valid;
  logic [PC_W-1:0] inst_buf;

  // Capture the fetched word on the first stalled cycle, while the SRAM output is still ours.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else if (fs_allowin) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !bus.ds_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= bus.inst_sram_rdata;
    end
  end

  // Present the held word once captured, otherwise the live SRAM data.
  always_comb begin
    fs_inst = buf_valid ? inst_buf : bus.inst_sram_rdata;
  end
`else
  // SRAM keeps its output while disabled, so the live read data is the IF instruction.
  always_comb begin
    fs_inst = bus.inst_sram_rdata;
  end
`endif

  // Outputs to decode and the SRAM; a taken branch turns the IF instruction into a bubble.
  always_comb begin
    bus.fs_to_ds_valid  = fs_valid && FS_READY_GO && !br_taken;
    bus.fs_to_ds_bus    = {fs_inst, fs_pc};
    bus.inst_sram_en    = to_fs_valid && fs_allowin;
    bus.inst_sram_we    = 4'h0;
    bus.inst_sram_addr  = nextpc;
    bus.inst_sram_wdata = 32'h0;
  end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The SRAM model returns ~addr one cycle after an
// enabled read; with FS_INST_BUF_EN it scrambles its output while disabled.
module tb_if_stage;
  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic corrupt;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction SRAM model
  always @(posedge clk) begin
    if (bus.inst_sram_en)
      bus.inst_sram_rdata <= ~bus.inst_sram_addr;
    else if (corrupt)
      bus.inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pkt(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  // Check decode-side outputs for an instruction at pc, plus the pending fetch.
  task automatic chk_deliver(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, "_valid"}, 64'(bus.fs_to_ds_valid), 64'(1));
    chk({tag, "_bus"},   bus.fs_to_ds_bus, pkt(pc));
    chk({tag, "_en"},    64'(bus.inst_sram_en), 64'(1));
    chk({tag, "_addr"},  64'(bus.inst_sram_addr), 64'(addr));
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
`ifdef FS_INST_BUF_EN
    corrupt = 1'b1;
`else
    corrupt = 1'b0;
`endif
    reset              = 1'b1;
    bus.ds_allowin     = 1'b1;
    bus.br_bus         = 33'h0;
    bus.inst_sram_rdata = 32'h0;

    // Reset holds everything quiet
    step(); step();
    chk("rst_en",    64'(bus.inst_sram_en),   64'(0));
    chk("rst_valid", 64'(bus.fs_to_ds_valid), 64'(0));

    // Reset release: sequential fetch from 0x1C000000
    reset = 1'b0;
    #1;
    chk("rel_en",   64'(bus.inst_sram_en),   64'(1));
    chk("rel_addr", 64'(bus.inst_sram_addr), 64'(32'h1C00_0000));
    chk("rel_valid0", 64'(bus.fs_to_ds_valid), 64'(0));
    step();
    chk_deliver("seq0", 32'h1C00_0000, 32'h1C00_0004);
    step();
    chk_deliver("seq1", 32'h1C00_0004, 32'h1C00_0008);
    step();
    chk_deliver("seq2", 32'h1C00_0008, 32'h1C00_000C);

    // Decode stall for 3 cycles with 0x1C000008 in IF
    bus.ds_allowin = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_en",    64'(bus.inst_sram_en),   64'(0));
      chk("stall_valid", 64'(bus.fs_to_ds_valid), 64'(1));
      chk("stall_bus",   bus.fs_to_ds_bus, pkt(32'h1C00_0008));
      if (i < 2) step();
    end
    bus.ds_allowin = 1'b1;
    #1;
    chk("unstall_addr", 64'(bus.inst_sram_addr), 64'(32'h1C00_000C));
    step();
    chk_deliver("seq3", 32'h1C00_000C, 32'h1C00_0010);

    // Taken branch with decode accepting
    bus.br_bus = {1'b1, 32'h1C00_0100};
    #1;
    chk("br_valid", 64'(bus.fs_to_ds_valid), 64'(0));
    chk("br_addr",  64'(bus.inst_sram_addr), 64'(32'h1C00_0100));
    step();
    bus.br_bus = 33'h0;
    #1;
    chk_deliver("br_tgt", 32'h1C00_0100, 32'h1C00_0104);

    // Branch held through a 2-cycle stall
    bus.ds_allowin = 1'b0;
    bus.br_bus     = {1'b1, 32'h1C00_0200};
    #1;
    chk("bst_en0",    64'(bus.inst_sram_en),   64'(0));
    chk("bst_valid0", 64'(bus.fs_to_ds_valid), 64'(0));
    step();
    chk("bst_en1",    64'(bus.inst_sram_en),   64'(0));
    chk("bst_valid1", 64'(bus.fs_to_ds_valid), 64'(0));
    bus.ds_allowin = 1'b1;
    #1;
    chk("bst_en2",    64'(bus.inst_sram_en),   64'(1));
    chk("bst_addr",   64'(bus.inst_sram_addr), 64'(32'h1C00_0200));
    chk("bst_valid2", 64'(bus.fs_to_ds_valid), 64'(0));
    step();
    bus.br_bus = 33'h0;
    #1;
    chk_deliver("bst_tgt", 32'h1C00_0200, 32'h1C00_0204);

    // Unaligned target passes through unchanged
    bus.br_bus = {1'b1, 32'h1C00_0301};
    #1;
    chk("ua_addr", 64'(bus.inst_sram_addr), 64'(32'h1C00_0301));
    step();
    bus.br_bus = 33'h0;
    #1;
    chk_deliver("ua_tgt", 32'h1C00_0301, 32'h1C00_0305);

    // Wrap-around at the top of the address space
    bus.br_bus = {1'b1, 32'hFFFF_FFFC};
    #1;
    chk("wr_addr0", 64'(bus.inst_sram_addr), 64'(32'hFFFF_FFFC));
    step();
    bus.br_bus = 33'h0;
    #1;
    chk_deliver("wr_top", 32'hFFFF_FFFC, 32'h0000_0000);
    step();
    chk_deliver("wr_zero", 32'h0000_0000, 32'h0000_0004);

    // Reset asserted in the middle of a stall
    bus.ds_allowin = 1'b0;
    #1;
    chk("rs_en", 64'(bus.inst_sram_en), 64'(0));
    step();
    chk("rs_hold", bus.fs_to_ds_bus, pkt(32'h0000_0000));
`ifdef FS_INST_BUF_EN
    chk("rs_buf1", 64'(dut.buf_valid), 64'(1));
`endif
    reset = 1'b1;
    #1;
    chk("rs_en_rst", 64'(bus.inst_sram_en), 64'(0));
    step();
    chk("rs_valid", 64'(bus.fs_to_ds_valid), 64'(0));
`ifdef FS_INST_BUF_EN
    chk("rs_buf0", 64'(dut.buf_valid), 64'(0));
`endif
    reset          = 1'b0;
    bus.ds_allowin = 1'b1;
    #1;
    chk("rs_rel_addr", 64'(bus.inst_sram_addr), 64'(32'h1C00_0000));
    step();
    chk_deliver("rs_seq", 32'h1C00_0000, 32'h1C00_0004);

    // Branch while IF is empty fetches the target directly
    reset = 1'b1;
    step(); step();
    reset      = 1'b0;
    bus.br_bus = {1'b1, 32'h1C00_0400};
    #1;
    chk("emp_en",    64'(bus.inst_sram_en),   64'(1));
    chk("emp_addr",  64'(bus.inst_sram_addr), 64'(32'h1C00_0400));
    chk("emp_valid", 64'(bus.fs_to_ds_valid), 64'(0));
    step();
    bus.br_bus = 33'h0;
    #1;
    chk_deliver("emp_tgt", 32'h1C00_0400, 32'h1C00_0404);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
